// File: rtl/ps2_key_event_queue.sv
// PS/2 Set-2 key event queue.
// Parses E0 (extended) and F0 (break) prefixes from a stream of scancode
// bytes and queues complete key events in a show-ahead FIFO for the host.
module ps2_key_event_queue #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        code_in,
  input  logic              code_valid,
  input  logic              rd_en,
  input  logic              clear,
  output logic [7:0]        evt_code,
  output logic              evt_break,
  output logic              evt_ext,
  output logic              evt_valid,
  output logic              overflow,
  output logic [ADDR_W:0]   count
);

  // Prefix-parser states: bit 0 records an E0 prefix, bit 1 an F0 prefix.
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_E0   = 2'b01;
  localparam logic [1:0] S_F0   = 2'b10;
  localparam logic [1:0] S_E0F0 = 2'b11;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   eff_count;
  logic              overflow_q, overflow_d;
  logic [9:0]        head_q, head_d;
  logic [9:0]        mem_q [DEPTH];

  logic              push_req;
  logic [9:0]        push_data;
  logic              do_push;
  logic              do_pop;

  // Prefix parser: decides the next state and whether this byte completes an event.
  always_comb begin
    state_d   = state_q;
    push_req  = 1'b0;
    push_data = {(state_q == S_E0) || (state_q == S_E0F0),
                 (state_q == S_F0) || (state_q == S_E0F0),
                 code_in};
    if (code_valid) begin
      case (code_in)
        8'hE0: state_d = S_E0;  // a fresh E0 always restarts the prefix
        8'hF0: begin
          if (state_q == S_E0 || state_q == S_E0F0) state_d = S_E0F0;
          else                                      state_d = S_F0;
        end
        8'h00, 8'hFF: state_d = S_IDLE;  // keyboard error/overrun: drop the sequence
        default: begin
          push_req = 1'b1;
          state_d  = S_IDLE;
        end
      endcase
    end
    if (clear) state_d = S_IDLE;
  end

  // FIFO bookkeeping: push/pop arbitration, pointers, count, sticky overflow, head entry.
  always_comb begin
    do_pop     = rd_en && (count_q != '0) && !clear;
    do_push    = push_req && !clear && ((count_q != FULL_CNT) || do_pop);
    wr_ptr_d   = do_push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d   = do_pop  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    count_d    = count_q + (ADDR_W+1)'(do_push) - (ADDR_W+1)'(do_pop);
    overflow_d = overflow_q | (push_req && !clear && !do_push);
    eff_count  = count_q - (ADDR_W+1)'(do_pop);
    head_d     = head_q;
    // The incoming event becomes the head only if nothing else remains stored;
    // otherwise the head is whatever the (possibly advanced) read pointer selects.
    // When the FIFO drains, the head fields keep their last value.
    if (do_push && (eff_count == '0)) head_d = push_data;
    else if (count_d != '0)           head_d = mem_q[rd_ptr_d];
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end
  end

  // Control and head registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      head_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      head_q     <= head_d;
    end
  end

  // Event storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign evt_ext   = head_q[9];
  assign evt_break = head_q[8];
  assign evt_code  = head_q[7:0];
  assign evt_valid = (count_q != '0);
  assign overflow  = overflow_q;
  assign count     = count_q;

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Testbench for ps2_key_event_queue: directed prefix/FIFO cases plus random
// byte streams, with a queue scoreboard fed by a prefix-flag reference model.
module tb_ps2_key_event_queue;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [7:0]        code_in = 8'h00;
  logic              code_valid = 1'b0;
  logic              rd_en = 1'b0;
  logic              clear = 1'b0;
  logic [7:0]        evt_code;
  logic              evt_break;
  logic              evt_ext;
  logic              evt_valid;
  logic              overflow;
  logic [ADDR_W:0]   count;

  ps2_key_event_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .code_in(code_in), .code_valid(code_valid),
    .rd_en(rd_en), .clear(clear), .evt_code(evt_code), .evt_break(evt_break),
    .evt_ext(evt_ext), .evt_valid(evt_valid), .overflow(overflow), .count(count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errs   = 0;

  // Reference model state: pending prefix flags, stored-event count, overflow.
  logic       m_ext = 1'b0;
  logic       m_brk = 1'b0;
  int         m_cnt = 0;
  logic       m_ovf = 1'b0;
  logic [9:0] sb_q[$];   // expected events {ext, brk, code}, oldest first

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ext = 1'b0; m_brk = 1'b0; m_cnt = 0; m_ovf = 1'b0;
    sb_q.delete();
  endtask

  // Apply the effect of one clock edge to the model. The monitor has already
  // taken the popped entry off the scoreboard before this edge.
  task automatic model_edge(input logic v, input logic [7:0] c, input logic r, input logic cl);
    int pop;
    if (cl) begin
      model_reset();
      return;
    end
    pop = (r && m_cnt > 0) ? 1 : 0;
    m_cnt = m_cnt - pop;
    if (v) begin
      if (c == 8'h00 || c == 8'hFF) begin
        m_ext = 1'b0; m_brk = 1'b0;
      end else if (c == 8'hE0) begin
        m_ext = 1'b1; m_brk = 1'b0;
      end else if (c == 8'hF0) begin
        m_brk = 1'b1;
      end else begin
        if (m_cnt < DEPTH) begin
          sb_q.push_back({m_ext, m_brk, c});
          m_cnt++;
        end else begin
          m_ovf = 1'b1;
        end
        m_ext = 1'b0; m_brk = 1'b0;
      end
    end
  endtask

  task automatic step(input logic v, input logic [7:0] c, input logic r, input logic cl);
    code_valid = v; code_in = c; rd_en = r; clear = cl;
    @(posedge clk);
    model_edge(v, c, r, cl);
    #1;
    code_valid = 1'b0; rd_en = 1'b0; clear = 1'b0; code_in = 8'h00;
  endtask

  task automatic send(input logic [7:0] c);
    step(1'b1, c, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && m_cnt > 0; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("drain_empty", 32'(count), 32'd0);
  endtask

  // Monitor: checks status every cycle and compares the head against the
  // scoreboard, retiring an entry whenever the host pops it.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("count", 32'(count), 32'(m_cnt));
      chk("evt_valid", 32'(evt_valid), 32'(m_cnt > 0));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (evt_valid && sb_q.size() > 0)
        chk("head", {22'd0, evt_ext, evt_break, evt_code}, {22'd0, sb_q[0]});
      if (rd_en && evt_valid && !clear) begin
        if (sb_q.size() == 0) chk("pop_unexpected", 32'd1, 32'd0);
        else void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    int rd_pct;
    logic [7:0] b;
    // Power-on reset.
    #1 rst_n = 1'b0;
    #2;
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_code", 32'(evt_code), 32'd0);
    chk("rst_flags", {30'd0, evt_ext, evt_break}, 32'd0);
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();

    // Single make code, then pop.
    send(8'h1C);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Break, extended make, extended break.
    send(8'hF0); send(8'h1C);
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    drain();

    // Malformed prefixes.
    send(8'hF0); send(8'hE0); send(8'h6B);
    send(8'hE0); send(8'hFF); send(8'h1C);
    send(8'hE1); send(8'hAA); send(8'hFA); send(8'hEE); send(8'hFE);
    drain();

    // Overfill: 0x01..0x09 with no reads.
    for (int i = 1; i <= DEPTH + 1; i++) send(8'(i));
    chk("ovf_set", 32'(overflow), 32'd1);
    drain();
    chk("ovf_sticky", 32'(overflow), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Full FIFO with simultaneous push and pop.
    for (int i = 1; i <= DEPTH; i++) send(8'(8'h10 + i));
    step(1'b1, 8'h2A, 1'b1, 1'b0);
    chk("full_pushpop_ovf", 32'(overflow), 32'd0);
    drain();

    // Empty FIFO with simultaneous push and pop.
    step(1'b1, 8'h33, 1'b1, 1'b0);
    chk("empty_pushpop_cnt", 32'(count), 32'd1);
    drain();

    // Clear during a pending break prefix, then a clean make.
    send(8'h05);
    send(8'hF0);
    step(1'b1, 8'h1C, 1'b0, 1'b1);
    send(8'h1C);
    drain();

    // Asynchronous reset mid-stream.
    send(8'hE0); send(8'hF0); send(8'h4A); send(8'hE0);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(evt_valid), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_code", 32'(evt_code), 32'd0);
    chk("mid_rst_flags", {30'd0, evt_ext, evt_break}, 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(8'h4A);   // prefix state must be gone: plain make
    drain();

    // Random streams with varying read pressure.
    for (int blk = 0; blk < 12; blk++) begin
      rd_pct = (blk % 3 == 0) ? 5 : ((blk % 3 == 1) ? 40 : 80);
      for (int i = 0; i < 200; i++) begin
        case ($urandom_range(0, 9))
          0, 1:    b = 8'hE0;
          2, 3:    b = 8'hF0;
          4:       b = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'hFF;
          default: b = 8'($urandom);
        endcase
        step($urandom_range(0, 3) != 0, b, $urandom_range(0, 99) < rd_pct,
             $urandom_range(0, 127) == 0);
      end
    end
    drain();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
